shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 108 ++++++++++
 tb/tb_shift_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one shifter; result is registered (1-cycle latency).
// Define SHIFT_ARB_ROUND_ROBIN_EN for round-robin contention; default gives req0 fixed priority.
module shift_arbiter #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [N-1:0]         req0_in,
    input  logic [$clog2(N)-1:0] req0_shamt,
    input  logic [1:0]           req0_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [N-1:0]         req1_in,
    input  logic [$clog2(N)-1:0] req1_shamt,
    input  logic [1:0]           req1_op,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [N-1:0]         resp_data,
    output logic                 resp_id
);
    localparam int SW = $clog2(N);

    logic          free;
    logic          sel1;
    logic          gnt0;
    logic          gnt1;
    logic          gnt;
    logic [N-1:0]  op_in;
    logic [SW-1:0] op_sh;
    logic [1:0]    op_op;
    logic [N-1:0]  shres;
    logic [N-1:0]  data_q, data_d;
    logic          id_q, id_d;
    logic          valid_q, valid_d;

    assign free = ~valid_q | resp_ready;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    logic prio_q, prio_d;
    assign sel1 = req1_valid & (~req0_valid | prio_q);
`else
    assign sel1 = req1_valid & ~req0_valid;
`endif

    // Grant never looks at operand fields, only valids and result-register state.
    assign gnt0 = ~rst & free & req0_valid & ~sel1;
    assign gnt1 = ~rst & free & sel1;
    assign gnt  = gnt0 | gnt1;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        op_in = sel1 ? req1_in    : req0_in;
        op_sh = sel1 ? req1_shamt : req0_shamt;
        op_op = sel1 ? req1_op    : req0_op;
        shres = op_in;
        unique case (op_op)
            2'b00:   shres = op_in << op_sh;
            2'b01:   shres = op_in >> op_sh;
            2'b10:   shres = $signed(op_in) >>> op_sh;
            default: shres = op_in;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        id_d    = id_q;
        valid_d = valid_q;
        if (gnt) begin
            data_d  = shres;
            id_d    = sel1;
            valid_d = 1'b1;
        end else if (resp_ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    always_comb begin
        prio_d = prio_q;
        if (gnt) prio_d = ~sel1;
    end

    always_ff @(posedge clk) begin
        if (rst) prio_q <= 1'b0;
        else     prio_q <= prio_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            id_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign resp_valid = valid_q;
    assign resp_data  = data_q;
    assign resp_id    = id_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed-vector scoreboard bench for shift_arbiter.
// Build with +define+SHIFT_ARB_ROUND_ROBIN_EN to check round-robin expectations.
module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_in, req1_in;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_op, req1_op;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;

    int          checks = 0;
    int          errors = 0;
    bit          gprev  = 1'b0;
    logic [32:0] sb_q[$];

    shift_arbiter #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in(req0_in), .req0_shamt(req0_shamt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in(req1_in), .req1_shamt(req1_shamt), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [32:0] act,
                       input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
            logic [32:0] e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got id=%0d data=%h, expected none",
                         resp_id, resp_data);
            end else begin
                e = sb_q.pop_front();
                if ({resp_id, resp_data} !== e) begin
                    errors++;
                    $display("FAIL resp: got id=%0d data=%h, expected id=%0d data=%h",
                             resp_id, resp_data, e[32], e[31:0]);
                end
            end
        end
    end

    // One cycle of stimulus; g = 0 no grant, 1 req0 granted, 2 req1 granted.
    task automatic cyc(input logic v0, input logic [31:0] d0,
                       input logic [4:0] s0, input logic [1:0] o0,
                       input logic v1, input logic [31:0] d1,
                       input logic [4:0] s1, input logic [1:0] o1,
                       input logic rr, input int g, input logic [31:0] exp);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        req0_valid = v0; req0_in = d0; req0_shamt = s0; req0_op = o0;
        req1_valid = v1; req1_in = d1; req1_shamt = s1; req1_op = o1;
        resp_ready = rr;
        @(negedge clk);
        if (gprev) chk("latency_valid", {32'd0, resp_valid}, 33'd1);
        chk("req0_ready", {32'd0, req0_ready}, {32'd0, g == 1});
        chk("req1_ready", {32'd0, req1_ready}, {32'd0, g == 2});
        if (g != 0) sb_q.push_back({g == 2, exp});
        gprev = (g != 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic rst_cyc();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("rst_req0_ready", {32'd0, req0_ready}, 33'd0);
        chk("rst_req1_ready", {32'd0, req1_ready}, 33'd0);
        gprev = 1'b0;
    endtask

    initial begin
        int id;
        rst = 1'b1;
        req0_valid = 0; req0_in = 0; req0_shamt = 0; req0_op = 0;
        req1_valid = 0; req1_in = 0; req1_shamt = 0; req1_op = 0;
        resp_ready = 0;

        rst_cyc();
        rst_cyc();
        chk("reset_state", {resp_id, resp_data}, 33'd0);
        chk("reset_valid", {32'd0, resp_valid}, 33'd0);

        // SRA of negative operand, first grant in first cycle out of reset
        cyc(1, 32'h80000000, 4, 2'b10, 0, 0, 0, 0, 1, 1, 32'hF8000000);
        // req1 back to back: SRL 31 then SLL 31
        cyc(0, 0, 0, 0, 1, 32'h80000001, 31, 2'b01, 1, 2, 32'h00000001);
        cyc(0, 0, 0, 0, 1, 32'h80000001, 31, 2'b00, 1, 2, 32'h80000000);
        idle();
        idle();
        chk("drain_clears_valid", {32'd0, resp_valid}, 33'd0);

        // Sustained contention
        for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
            id = i % 2;
`else
            id = 0;
`endif
            cyc(1, 32'hA5A50000, 3, 2'b11, 1, 32'h00005A5A, 3, 2'b11, 1,
                id + 1, (id == 1) ? 32'h00005A5A : 32'hA5A50000);
        end
        idle();
        idle();

        // Backpressure: held result, no grants, then grant on the drain cycle
        cyc(1, 32'h0000FFFF, 8, 2'b00, 0, 0, 0, 0, 0, 1, 32'h00FFFF00);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'hAAAA0000, 0, 2'b11, 1, 32'h00005555, 0, 2'b11, 0, 0, 0);
            chk("bp_hold", {resp_valid, resp_data}, {1'b1, 32'h00FFFF00});
        end
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
        cyc(1, 32'hAAAA0000, 0, 2'b11, 1, 32'h00005555, 0, 2'b11, 1, 2, 32'h00005555);
`else
        cyc(1, 32'hAAAA0000, 0, 2'b11, 1, 32'h00005555, 0, 2'b11, 1, 1, 32'hAAAA0000);
`endif
        idle();

        // Pass-through and zero shifts, plus shift boundaries
        cyc(1, 32'h12345678, 7, 2'b11, 0, 0, 0, 0, 1, 1, 32'h12345678);
        cyc(1, 32'h12345678, 0, 2'b00, 0, 0, 0, 0, 1, 1, 32'h12345678);
        cyc(1, 32'h12345678, 0, 2'b01, 0, 0, 0, 0, 1, 1, 32'h12345678);
        cyc(1, 32'h12345678, 0, 2'b10, 0, 0, 0, 0, 1, 1, 32'h12345678);
        cyc(0, 0, 0, 0, 1, 32'hF0000000, 4, 2'b01, 1, 2, 32'h0F000000);
        cyc(0, 0, 0, 0, 1, 32'hF0000000, 4, 2'b10, 1, 2, 32'hFF000000);
        cyc(1, 32'h7FFFFFFF, 31, 2'b10, 0, 0, 0, 0, 1, 1, 32'h00000000);
        cyc(1, 32'h00000001, 31, 2'b00, 0, 0, 0, 0, 1, 1, 32'h80000000);
        idle();
        idle();

        // Reset while a result is held under backpressure: result is discarded
        cyc(1, 32'hDEADBEEF, 0, 2'b11, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_cyc();
        rst_cyc();
        chk("midrst_state", {resp_valid, resp_data}, 33'd0);
        chk("midrst_id", {32'd0, resp_id}, 33'd0);
        sb_q.delete();

        // Priority pointer is back at req0 after reset
        cyc(1, 32'h00000011, 0, 2'b11, 1, 32'h00000022, 0, 2'b11, 1, 1, 32'h00000011);
        idle();
        idle();

        chk("scoreboard_empty", 33'(sb_q.size()), 33'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
